mem_port_scheduler: RTL and testbench



---
 rtl/mem_port_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler for the single L2 port shared by i-cache, d-cache and
// write-back buffer, with a read-after-write hold on the buffered dirty line.
package mps_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  localparam int NUM_REQ = 3;

  typedef struct packed {
    logic      rd;
    logic      wr;
    lc3b_word  addr;
    cache_line wdata;
  } req_t;
endpackage

// Per-requester slot: eligibility plus the service/resp decode for its grant id.
module mps_slot #(
  parameter logic [1:0] ID = 2'd0
) (
  input  logic       busy,
  input  logic [1:0] gnt,
  input  logic       pmem_resp,
  input  logic       req_vld,
  input  logic       hold,
  output logic       elig,
  output logic       service,
  output logic       resp
);
  assign elig    = req_vld & ~hold;
  assign service = busy & (gnt == ID);
  assign resp    = service & pmem_resp;
endmodule

module mem_port_scheduler
  import mps_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          ipmem_address,
  input  logic                 ipmem_read,
  input  logic [15:0]          dpmem_address,
  input  logic [127:0]         dpmem_wdata,
  input  logic                 dpmem_read,
  input  logic                 dpmem_write,
  input  logic [15:0]          wb_address,
  input  logic [127:0]         wb_wdata,
  input  logic                 wb_write,
  input  logic [127:0]         pmem_rdata,
  input  logic                 pmem_resp,
  output logic [15:0]          pmem_address,
  output logic [127:0]         pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [127:0]         mem_rdata,
  output logic                 instr_resp,
  output logic                 data_resp,
  output logic                 wb_resp,
  output logic                 instr_service,
  output logic                 data_service,
  output logic                 wb_service
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_d;
  logic [1:0]         gnt, rr_ptr;
  logic [1:0]         pick;
  logic               pick_vld;
  req_t               sel_req;
  req_t [NUM_REQ-1:0] reqs;
  logic [NUM_REQ-1:0] req_vld, hold, elig, service, resp;
  logic               raw_hold;

  function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // D with both strobes set is a write, so only a pure read is subject to the RAW hold.
  assign reqs[0] = '{rd: ipmem_read, wr: 1'b0, addr: ipmem_address, wdata: '0};
  assign reqs[1] = '{rd: dpmem_read & ~dpmem_write, wr: dpmem_write,
                     addr: dpmem_address, wdata: dpmem_wdata};
  assign reqs[2] = '{rd: 1'b0, wr: wb_write, addr: wb_address, wdata: wb_wdata};

  assign raw_hold = dpmem_read & ~dpmem_write & wb_write &
                    (dpmem_address[15:4] == wb_address[15:4]);
  assign hold     = {1'b0, raw_hold, 1'b0};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign req_vld[i] = reqs[i].rd | reqs[i].wr;
    mps_slot #(.ID(2'(i))) u_slot (
      .busy     (state == BUSY),
      .gnt      (gnt),
      .pmem_resp(pmem_resp),
      .req_vld  (req_vld[i]),
      .hold     (hold[i]),
      .elig     (elig[i]),
      .service  (service[i]),
      .resp     (resp[i])
    );
  end

  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && elig[rr_add(rr_ptr, 2'(k))]) begin
        pick     = rr_add(rr_ptr, 2'(k));
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (pick)
      2'd1:    sel_req = reqs[1];
      2'd2:    sel_req = reqs[2];
      default: sel_req = reqs[0];
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_vld)  state_d = BUSY;
      BUSY:    if (pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Request registers: captured at the grant edge, strobes cleared at the resp edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= 2'd0;
      rr_ptr       <= 2'd0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_vld) begin
        gnt          <= pick;
        pmem_address <= sel_req.addr;
        pmem_wdata   <= sel_req.wdata;
        pmem_read    <= sel_req.rd;
        pmem_write   <= sel_req.wr;
      end
    end else if (pmem_resp) begin
      rr_ptr     <= rr_add(gnt, 2'd1);
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  assign mem_rdata     = pmem_rdata;
  assign instr_service = service[0];
  assign data_service  = service[1];
  assign wb_service    = service[2];
  assign instr_resp    = resp[0];
  assign data_resp     = resp[1];
  assign wb_resp       = resp[2];
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: timing, round-robin, RAW hold, reset.
module tb_mem_port_scheduler;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [15:0]  ipmem_address = '0, dpmem_address = '0, wb_address = '0;
  logic [127:0] dpmem_wdata = '0, wb_wdata = '0, pmem_rdata = '0;
  logic         ipmem_read = 0, dpmem_read = 0, dpmem_write = 0, wb_write = 0, pmem_resp = 0;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, mem_rdata;
  logic         pmem_read, pmem_write, instr_resp, data_resp, wb_resp;
  logic         instr_service, data_service, wb_service;

  int tests = 0, fails = 0;

  localparam logic [127:0] LINE_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] WB_W   = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D_W    = 128'hcafe_f00d_1234_5678_9abc_def0_0f0f_f0f0;

  mem_port_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .ipmem_address(ipmem_address), .ipmem_read(ipmem_read),
    .dpmem_address(dpmem_address), .dpmem_wdata(dpmem_wdata),
    .dpmem_read(dpmem_read), .dpmem_write(dpmem_write),
    .wb_address(wb_address), .wb_wdata(wb_wdata), .wb_write(wb_write),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .mem_rdata(mem_rdata),
    .instr_resp(instr_resp), .data_resp(data_resp), .wb_resp(wb_resp),
    .instr_service(instr_service), .data_service(data_service), .wb_service(wb_service)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One granted transaction: busy cycle with same-cycle resp, then the idle bubble.
  task automatic txn(input string tag, input logic [1:0] g, input logic [15:0] a,
                     input logic rd, input logic wr, input logic [127:0] wd,
                     input logic [1:0] next_rr);
    logic [2:0]   oh;
    logic [127:0] line;
    oh   = 3'b001 << g;
    line = {8{a}} ^ LINE_A;
    @(negedge clk); #1;
    chk({tag, " svc"},  {wb_service, data_service, instr_service}, oh);
    chk({tag, " addr"}, pmem_address, a);
    chk({tag, " strb"}, {pmem_read, pmem_write}, {rd, wr});
    if (wr) chk({tag, " wdata"}, pmem_wdata, wd);
    pmem_resp = 1; pmem_rdata = line; #1;
    chk({tag, " resp"},  {wb_resp, data_resp, instr_resp}, oh);
    chk({tag, " rdata"}, mem_rdata, line);
    @(negedge clk); pmem_resp = 0; #1;
    chk({tag, " idle svc"},  {wb_service, data_service, instr_service}, 3'b000);
    chk({tag, " idle strb"}, {pmem_read, pmem_write}, 2'b00);
    chk({tag, " rr_ptr"},    dut.rr_ptr, next_rr);
  endtask

  initial begin
    // reset state
    @(negedge clk); #1;
    chk("rst strb", {pmem_read, pmem_write}, 2'b00);
    chk("rst addr", pmem_address, 16'h0);
    chk("rst wdata", pmem_wdata, 128'h0);
    chk("rst svc", {wb_service, data_service, instr_service}, 3'b000);
    chk("rst rr", dut.rr_ptr, 2'd0);

    // single I read, L2 answers in cycle 4
    @(negedge clk); rst_n = 1; ipmem_read = 1; ipmem_address = 16'h1230; #1;
    chk("i c0 read", pmem_read, 1'b0);
    @(negedge clk); #1;
    chk("i c1 read", pmem_read, 1'b1);
    chk("i c1 addr", pmem_address, 16'h1230);
    chk("i c1 svc", {wb_service, data_service, instr_service}, 3'b001);
    ipmem_read = 0;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk); #1;
      chk("i mid read", pmem_read, 1'b1);
      chk("i mid resp", instr_resp, 1'b0);
    end
    @(negedge clk); pmem_resp = 1; pmem_rdata = LINE_A; #1;
    chk("i c4 read", pmem_read, 1'b1);
    chk("i c4 resp", {wb_resp, data_resp, instr_resp}, 3'b001);
    chk("i c4 rdata", mem_rdata, LINE_A);
    @(negedge clk); pmem_resp = 0; #1;
    chk("i c5 read", pmem_read, 1'b0);
    chk("i c5 svc", instr_service, 1'b0);
    chk("i c5 rr", dut.rr_ptr, 2'd1);

    // stray resp in IDLE
    pmem_resp = 1; #1;
    chk("stray resp", {wb_resp, data_resp, instr_resp}, 3'b000);
    @(negedge clk); pmem_resp = 0; #1;
    chk("stray svc", {wb_service, data_service, instr_service}, 3'b000);
    chk("stray strb", {pmem_read, pmem_write}, 2'b00);

    // round-robin with all three held from reset
    rst_n = 0;
    ipmem_read = 1; ipmem_address = 16'h1000;
    dpmem_read = 1; dpmem_address = 16'h2000;
    wb_write = 1; wb_address = 16'h3000; wb_wdata = WB_W;
    @(negedge clk); rst_n = 1;
    txn("rr I",  2'd0, 16'h1000, 1'b1, 1'b0, '0,   2'd1);
    txn("rr D",  2'd1, 16'h2000, 1'b1, 1'b0, '0,   2'd2);
    txn("rr WB", 2'd2, 16'h3000, 1'b0, 1'b1, WB_W, 2'd0);
    txn("rr I2", 2'd0, 16'h1000, 1'b1, 1'b0, '0,   2'd1);

    // RAW hold: D read on the buffered line waits for the drain
    ipmem_read = 0; dpmem_address = 16'h4008; wb_address = 16'h4000;
    txn("raw WB", 2'd2, 16'h4000, 1'b0, 1'b1, WB_W, 2'd0);
    wb_write = 0;
    txn("raw D",  2'd1, 16'h4008, 1'b1, 1'b0, '0,   2'd2);

    // bring rr_ptr back to 1, then D on a different line goes first
    dpmem_read = 0; ipmem_read = 1; ipmem_address = 16'h1111;
    txn("rr set I", 2'd0, 16'h1111, 1'b1, 1'b0, '0, 2'd1);
    ipmem_read = 0; dpmem_read = 1; dpmem_address = 16'h4010;
    wb_write = 1; wb_address = 16'h4000;
    txn("diff D", 2'd1, 16'h4010, 1'b1, 1'b0, '0, 2'd2);

    // D read+write together is a write
    wb_write = 0; dpmem_write = 1; dpmem_wdata = D_W;
    txn("rw D", 2'd1, 16'h4010, 1'b0, 1'b1, D_W, 2'd2);
    dpmem_read = 0; dpmem_write = 0;

    // reset mid-BUSY during a WB write, then a stray resp in IDLE
    wb_write = 1; wb_address = 16'h5550; wb_wdata = WB_W;
    @(negedge clk); #1;
    chk("mid wb svc", wb_service, 1'b1);
    chk("mid wb write", pmem_write, 1'b1);
    #1; rst_n = 0; wb_write = 0; pmem_resp = 1; #1;
    chk("async strb", {pmem_read, pmem_write}, 2'b00);
    chk("async addr", pmem_address, 16'h0);
    chk("async wdata", pmem_wdata, 128'h0);
    chk("async svc", {wb_service, data_service, instr_service}, 3'b000);
    chk("async resp", {wb_resp, data_resp, instr_resp}, 3'b000);
    chk("async rr", dut.rr_ptr, 2'd0);
    @(negedge clk); rst_n = 1; #1;
    chk("post rst resp", {wb_resp, data_resp, instr_resp}, 3'b000);
    @(negedge clk); #1;
    chk("post rst svc", {wb_service, data_service, instr_service}, 3'b000);
    chk("post rst strb", {pmem_read, pmem_write}, 2'b00);
    chk("post rst resp2", wb_resp, 1'b0);
    pmem_resp = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
